// File: rtl/coders_pkg.sv
// Shared types and width helper for the BCD encoder/decoder pair.
package coders_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_enc_state_t;

  // Binary width that holds any N-digit decimal value (same rule as bcd_decoder o_bin).
  function automatic int bcd_width(input int n);
    return 3*n + (n+2)/3;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_dabble_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_encoder_seq.sv
// Sequential binary-to-BCD encoder (double dabble, one input bit per clock).
// Optional o_overflow port: define LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN.
module bcd_encoder_seq
  import coders_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = bcd_width(N)
) (
  input  logic             i_clock,
  input  logic             i_aresetn,
  input  logic [W-1:0]     i_bin,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [4*N-1:0]   o_bcd,
  output logic             o_valid,
  input  logic             i_ready
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CW = $clog2(W);

  bcd_enc_state_t            r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [W-1:0]              r_bin;
  logic [N-1:0][3:0]         r_bcd;
  logic [N-1:0][3:0]         w_cor;
  logic [4*N-1:0]            w_bcd_shift;
  logic                      w_carry;
  logic                      w_accept;
  logic                      w_out_hs;
  logic                      w_last;

  // All digits are corrected in parallel; no carry between cells.
  for (genvar k = 0; k < N; k++) begin : g_dig
    bcd_dabble_digit u_dig (
      .i_digit (r_bcd[k]),
      .o_digit (w_cor[k])
    );
  end

  assign {w_carry, w_bcd_shift} = {w_cor, r_bin[W-1]};

  assign o_ready  = (r_state == IDLE) | ((r_state == DONE) & i_ready);
  assign o_valid  = (r_state == DONE);
  assign o_bcd    = r_bcd;
  assign w_accept = i_valid & o_ready;
  assign w_out_hs = o_valid & i_ready;
  assign w_last   = (r_cnt == CW'(W-1));

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)   w_state_nxt = DONE;
      DONE: begin
        // A new accept in DONE implies i_ready, so the result is consumed too.
        if (w_accept)      w_state_nxt = SHIFT;
        else if (w_out_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_cnt <= '0;
      r_bin <= '0;
      r_bcd <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_bin <= i_bin;
      r_bcd <= '0;
    end else if (r_state == SHIFT) begin
      r_cnt <= r_cnt + 1'b1;
      r_bin <= {r_bin[W-2:0], 1'b0};
      r_bcd <= w_bcd_shift;
    end
  end

`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
  logic r_overflow;

  // Any bit shifted out of the top digit means the input exceeded 10^N-1.
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn)              r_overflow <= 1'b0;
    else if (w_accept)           r_overflow <= 1'b0;
    else if (r_state == SHIFT)   r_overflow <= r_overflow | w_carry;
  end

  assign o_overflow = r_overflow & o_valid;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

endmodule

// File: tb/tb_bcd_encoder_seq.sv
// Directed bench for bcd_encoder_seq (N=3, W=10); overflow checks need the overflow macro.
module tb_bcd_encoder_seq;

  logic        i_clock = 1'b0;
  logic        i_aresetn;
  logic [9:0]  i_bin;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_bcd;
  logic        o_valid;
  logic        i_ready;
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
  logic        o_overflow;
`endif

  int errors = 0;
  int checks = 0;

  bcd_encoder_seq #(.N(3)) dut (
    .i_clock   (i_clock),
    .i_aresetn (i_aresetn),
    .i_bin     (i_bin),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_bcd     (o_bcd),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
    ,
    .o_overflow(o_overflow)
`endif
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drives one conversion; returns result and edges from accept to o_valid.
  task automatic convert(input logic [9:0] bin, output logic [11:0] bcd,
                         output logic ovf, output int lat);
    i_bin   = bin;
    i_valid = 1'b1;
    lat = 0;
    while (!o_ready && lat < 50) begin @(posedge i_clock); #1; lat++; end
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_bin   = '0;
    lat = 0;
    while (!o_valid && lat < 50) begin @(posedge i_clock); #1; lat++; end
    bcd = o_bcd;
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
    ovf = o_overflow;
`else
    ovf = 1'b0;
`endif
    if (i_ready) begin @(posedge i_clock); #1; end
  endtask

  task automatic test_reset();
    i_aresetn = 1'b0; i_valid = 1'b0; i_bin = '0; i_ready = 1'b1;
    #12;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", o_bcd); end
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
`endif
    @(negedge i_clock); i_aresetn = 1'b1;
    @(posedge i_clock); #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_basic();
    logic [11:0] bcd; logic ovf; int lat;
    logic [9:0]  vin [3]  = '{10'd0, 10'd999, 10'd255};
    logic [11:0] vexp [3] = '{12'h000, 12'h999, 12'h255};
    for (int i = 0; i < 3; i++) begin
      convert(vin[i], bcd, ovf, lat);
      checks++; if (bcd !== vexp[i]) begin errors++; $display("FAIL basic_bcd in=%0d got=%h exp=%h", vin[i], bcd, vexp[i]); end
      checks++; if (lat != 10) begin errors++; $display("FAIL basic_latency in=%0d got=%0d exp=10", vin[i], lat); end
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf in=%0d got=%b exp=0", vin[i], ovf); end
`endif
    end
  endtask

  task automatic test_overflow();
    logic [11:0] bcd; logic ovf; int lat;
    convert(10'd1000, bcd, ovf, lat);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL ovf1000_bcd got=%h exp=000", bcd); end
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1000_flag got=%b exp=1", ovf); end
`endif
    convert(10'd1023, bcd, ovf, lat);
    checks++; if (bcd !== 12'h023) begin errors++; $display("FAIL ovf1023_bcd got=%h exp=023", bcd); end
`ifdef LIBSV_CODERS_BCD_ENCODER_SEQ_OVERFLOW_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1023_flag got=%b exp=1", ovf); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%b exp=0", o_overflow); end
`endif
  endtask

  task automatic test_backpressure();
    logic [11:0] bcd; logic ovf; int lat;
    i_ready = 1'b0;
    convert(10'd468, bcd, ovf, lat);
    checks++; if (bcd !== 12'h468) begin errors++; $display("FAIL bp_bcd got=%h exp=468", bcd); end
    i_valid = 1'b1; i_bin = 10'd77;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clock); #1;
      checks++;
      if (o_valid !== 1'b1 || o_bcd !== 12'h468 || o_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d valid=%b bcd=%h ready=%b exp 1/468/0", c, o_valid, o_bcd, o_ready);
      end
    end
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", o_valid); end
    lat = 0;
    while (!o_valid && lat < 50) begin @(posedge i_clock); #1; lat++; end
    checks++; if (lat != 10 || o_bcd !== 12'h077) begin errors++; $display("FAIL bp_next lat=%0d bcd=%h exp 10/077", lat, o_bcd); end
    @(posedge i_clock); #1;
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [11:0] r1 = '0, r2 = '0;
    i_ready = 1'b1; i_valid = 1'b1; i_bin = 10'd12;
    @(posedge i_clock); #1;
    i_bin = 10'd34;
    for (int cyc = 1; cyc <= 40 && t2 < 0; cyc++) begin
      @(posedge i_clock); #1;
      if (t1 >= 0 && cyc == t1 + 1) i_valid = 1'b0;
      if (o_valid) begin
        if (t1 < 0) begin t1 = cyc; r1 = o_bcd; end
        else begin t2 = cyc; r2 = o_bcd; end
      end
    end
    i_valid = 1'b0;
    checks++; if (t1 != 10 || r1 !== 12'h012) begin errors++; $display("FAIL b2b_first t=%0d bcd=%h exp 10/012", t1, r1); end
    checks++; if (t2 - t1 != 11 || r2 !== 12'h034) begin errors++; $display("FAIL b2b_second dt=%0d bcd=%h exp 11/034", t2 - t1, r2); end
    @(posedge i_clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [11:0] bcd; logic ovf; int lat;
    i_valid = 1'b1; i_bin = 10'd999;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge i_clock);
    #1;
    checks++; if (o_bcd === 12'h000) begin errors++; $display("FAIL mid_progress got=%h exp nonzero", o_bcd); end
    i_aresetn = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_bcd !== 12'h000) begin errors++; $display("FAIL mid_reset valid=%b bcd=%h exp 0/000", o_valid, o_bcd); end
    @(negedge i_clock); i_aresetn = 1'b1;
    @(posedge i_clock); #1;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL mid_after ready=%b valid=%b exp 1/0", o_ready, o_valid); end
    convert(10'd42, bcd, ovf, lat);
    checks++; if (bcd !== 12'h042 || lat != 10) begin errors++; $display("FAIL mid_next bcd=%h lat=%0d exp 042/10", bcd, lat); end
  endtask

  task automatic test_exhaustive();
    logic [11:0] bcd; logic ovf; int lat;
    for (int v = 0; v < 1000; v++) begin
      convert(10'(v), bcd, ovf, lat);
      checks++;
      if (bcd !== to_bcd(v) || lat != 10 || ovf !== 1'b0) begin
        errors++; $display("FAIL exhaustive in=%0d bcd=%h lat=%0d ovf=%b exp %h/10/0", v, bcd, lat, ovf, to_bcd(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
